// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up sequencer: RESET# hold, CKE hold, tXPR, MR2/MR3/MR1/MR0, ZQCL, then ready.
// Define INIT_REFRESH_EN to add tREFI-paced auto-refresh handshaken through ref_req/ref_ack.
module ddr3_init_sequencer #(
   parameter int                ADDR_W   = 14,
   parameter int                BA_W     = 3,
   parameter int                CNT_W    = 20,
   parameter int                T_RST    = 100000,
   parameter int                T_CKE    = 250000,
   parameter int                T_XPR    = 60,
   parameter int                T_MRD    = 4,
   parameter int                T_MOD    = 12,
   parameter int                T_ZQINIT = 512,
   parameter logic [ADDR_W-1:0] MR0_VAL  = '0,
   parameter logic [ADDR_W-1:0] MR1_VAL  = '0,
   parameter logic [ADDR_W-1:0] MR2_VAL  = '0,
   parameter logic [ADDR_W-1:0] MR3_VAL  = '0,
   parameter logic              ODT_ON   = 1'b1,
   parameter int                T_REFI   = 3120,
   parameter int                T_RFC    = 64
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              init,
   input  logic              ref_ack,
   output logic              rst_n,
   output logic              cke,
   output logic              csbar,
   output logic              rasbar,
   output logic              casbar,
   output logic              webar,
   output logic [BA_W-1:0]   ba,
   output logic [ADDR_W-1:0] a,
   output logic              odt,
   output logic              ready,
   output logic              ref_req
);

   // state    | meaning
   // IDLE     | waiting for init, all outputs at reset values
   // RST_LOW  | RESET# low for T_RST
   // CKE_LOW  | RESET# high, CKE low for T_CKE
   // XPR      | CKE high, NOPs until MR2
   // MR2..MR0 | MRS on entry cycle, NOPs for T_MRD (T_MOD after MR0)
   // ZQ       | ZQCL on entry cycle, NOPs for T_ZQINIT
   // DONE     | ready, idle
   // REF      | REF on entry cycle, NOPs for T_RFC
   typedef enum logic [3:0] {
      S_IDLE, S_RST_LOW, S_CKE_LOW, S_XPR, S_MR2, S_MR3, S_MR1, S_MR0, S_ZQ, S_DONE, S_REF
   } state_t;

   localparam logic [3:0] CMD_DES  = 4'b1111;
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_MRS  = 4'b0000;
   localparam logic [3:0] CMD_REF  = 4'b0001;
   localparam logic [3:0] CMD_ZQCL = 4'b0110;
   localparam logic [ADDR_W-1:0] ZQ_ADDR = ADDR_W'(1024);

   // Timer counts down to zero; a zero timing collapses to a single-cycle state.
   function automatic logic [CNT_W-1:0] ld(input int t);
      return (t <= 1) ? '0 : CNT_W'(t - 1);
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  timer_q, timer_d;
   logic              tc;
   logic              entry;

   logic              rst_n_q, rst_n_d;
   logic              cke_q, cke_d;
   logic [3:0]        cmd_q, cmd_d;
   logic [BA_W-1:0]   ba_q, ba_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic              odt_q, odt_d;
   logic              ready_q, ready_d;
   logic              ref_req_q, ref_req_d;
   logic              ref_go;

`ifdef INIT_REFRESH_EN
   logic [CNT_W-1:0]  refi_q, refi_d;
   logic [3:0]        pending_q, pending_d;
   logic              refi_exp, ref_take, ref_inc;

   assign ref_go = ref_ack && (pending_q != 4'd0);

   always_comb begin
      refi_d    = '0;
      pending_d = '0;
      refi_exp  = 1'b0;
      ref_inc   = 1'b0;
      ref_take  = (state_q == S_DONE) && (state_d == S_REF);
      if ((state_q == S_DONE || state_q == S_REF) && state_d != S_RST_LOW) begin
         refi_exp  = (refi_q == '0);
         refi_d    = refi_exp ? ld(T_REFI) : refi_q - CNT_W'(1);
         // A take in the same cycle frees a slot, so a saturated expiry still counts.
         ref_inc   = refi_exp && ((pending_q != 4'd8) || ref_take);
         pending_d = pending_q + {3'b000, ref_inc} - {3'b000, ref_take};
      end else if (state_q == S_ZQ && state_d == S_DONE) begin
         refi_d = ld(T_REFI);
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         refi_q    <= '0;
         pending_q <= '0;
      end else begin
         refi_q    <= refi_d;
         pending_q <= pending_d;
      end
   end

   assign ref_req_d = (pending_d != 4'd0);
`else
   logic unused_refresh;
   assign unused_refresh = ^{ref_ack, ld(T_REFI)};
   assign ref_go         = 1'b0;
   assign ref_req_d      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q <= S_IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   assign tc = (timer_q == '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (init) state_d = S_RST_LOW;
         S_RST_LOW: if (tc)   state_d = S_CKE_LOW;
         S_CKE_LOW: if (tc)   state_d = S_XPR;
         S_XPR:     if (tc)   state_d = S_MR2;
         S_MR2:     if (tc)   state_d = S_MR3;
         S_MR3:     if (tc)   state_d = S_MR1;
         S_MR1:     if (tc)   state_d = S_MR0;
         S_MR0:     if (tc)   state_d = S_ZQ;
         S_ZQ:      if (tc)   state_d = S_DONE;
         S_DONE: begin
            if (init)        state_d = S_RST_LOW;
            else if (ref_go) state_d = S_REF;
         end
         S_REF:     if (tc)   state_d = S_DONE;
         default:             state_d = S_IDLE;
      endcase

      timer_d = timer_q;
      if (state_d != state_q) begin
         case (state_d)
            S_RST_LOW:               timer_d = ld(T_RST);
            S_CKE_LOW:               timer_d = ld(T_CKE);
            S_XPR:                   timer_d = ld(T_XPR);
            S_MR2, S_MR3, S_MR1:     timer_d = ld(T_MRD);
            S_MR0:                   timer_d = ld(T_MOD);
            S_ZQ:                    timer_d = ld(T_ZQINIT);
            S_REF:                   timer_d = ld(T_RFC);
            default:                 timer_d = '0;
         endcase
      end else if (!tc) begin
         timer_d = timer_q - CNT_W'(1);
      end
   end

   // Outputs are decoded from the next state so the registered pins line up with the state.
   assign entry = (state_d != state_q);

   always_comb begin
      rst_n_d = 1'b1;
      cke_d   = 1'b1;
      cmd_d   = CMD_NOP;
      ba_d    = ba_q;
      a_d     = a_q;
      odt_d   = 1'b0;
      ready_d = 1'b0;
      case (state_d)
         S_IDLE, S_RST_LOW: begin
            rst_n_d = 1'b0;
            cke_d   = 1'b0;
            cmd_d   = CMD_DES;
            ba_d    = '0;
            a_d     = '0;
         end
         S_CKE_LOW: begin
            cke_d = 1'b0;
            cmd_d = CMD_DES;
            ba_d  = '0;
            a_d   = '0;
         end
         S_MR2: if (entry) begin cmd_d = CMD_MRS; ba_d = BA_W'(2); a_d = MR2_VAL; end
         S_MR3: if (entry) begin cmd_d = CMD_MRS; ba_d = BA_W'(3); a_d = MR3_VAL; end
         S_MR1: if (entry) begin cmd_d = CMD_MRS; ba_d = BA_W'(1); a_d = MR1_VAL; end
         S_MR0: if (entry) begin cmd_d = CMD_MRS; ba_d = BA_W'(0); a_d = MR0_VAL; end
         S_ZQ:  if (entry) begin cmd_d = CMD_ZQCL; ba_d = '0; a_d = ZQ_ADDR; end
         S_DONE: begin
            ready_d = 1'b1;
            odt_d   = ODT_ON;
         end
         S_REF: begin
            odt_d = ODT_ON;
            if (entry) cmd_d = CMD_REF;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         rst_n_q   <= 1'b0;
         cke_q     <= 1'b0;
         cmd_q     <= CMD_DES;
         ba_q      <= '0;
         a_q       <= '0;
         odt_q     <= 1'b0;
         ready_q   <= 1'b0;
         ref_req_q <= 1'b0;
      end else begin
         rst_n_q   <= rst_n_d;
         cke_q     <= cke_d;
         cmd_q     <= cmd_d;
         ba_q      <= ba_d;
         a_q       <= a_d;
         odt_q     <= odt_d;
         ready_q   <= ready_d;
         ref_req_q <= ref_req_d;
      end
   end

   assign rst_n                         = rst_n_q;
   assign cke                           = cke_q;
   assign {csbar, rasbar, casbar, webar} = cmd_q;
   assign ba                            = ba_q;
   assign a                             = a_q;
   assign odt                           = odt_q;
   assign ready                         = ready_q;
   assign ref_req                       = ref_req_q;

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Bench for ddr3_init_sequencer: timeline model checked every cycle plus literal timing pins.
module tb_ddr3_init_sequencer;
   localparam int ADDR_W = 14, BA_W = 3, CNT_W = 20;
   localparam int T_RST = 10, T_CKE = 20, T_XPR = 5, T_MRD = 4, T_MOD = 12;
   localparam int T_ZQINIT = 30, T_REFI = 100, T_RFC = 8;
   localparam logic [13:0] MR0 = 14'h0520, MR1 = 14'h0044, MR2 = 14'h0018, MR3 = 14'h0004;
   // Offsets from the cycle init is presented, derived from the timing rules.
   localparam int OFF_K  = T_RST + 1 + T_CKE;
   localparam int OFF_M2 = OFF_K + T_XPR;
   localparam int OFF_M3 = OFF_M2 + T_MRD;
   localparam int OFF_M1 = OFF_M3 + T_MRD;
   localparam int OFF_M0 = OFF_M1 + T_MRD;
   localparam int OFF_Z  = OFF_M0 + T_MOD;
   localparam int OFF_D  = OFF_Z + T_ZQINIT;

   logic clk = 1'b0, RESET = 1'b1, init = 1'b0, ref_ack = 1'b0;
   logic rst_n, cke, csbar, rasbar, casbar, webar, odt, ready, ref_req;
   logic [BA_W-1:0]   ba;
   logic [ADDR_W-1:0] a;
   logic [3:0] cmd;
   assign cmd = {csbar, rasbar, casbar, webar};

   ddr3_init_sequencer #(
      .ADDR_W(ADDR_W), .BA_W(BA_W), .CNT_W(CNT_W), .T_RST(T_RST), .T_CKE(T_CKE),
      .T_XPR(T_XPR), .T_MRD(T_MRD), .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT),
      .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3), .ODT_ON(1'b1),
      .T_REFI(T_REFI), .T_RFC(T_RFC)
   ) dut (
      .clk(clk), .RESET(RESET), .init(init), .ref_ack(ref_ack), .rst_n(rst_n), .cke(cke),
      .csbar(csbar), .rasbar(rasbar), .casbar(casbar), .webar(webar), .ba(ba), .a(a),
      .odt(odt), .ready(ready), .ref_req(ref_req)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: m_s is the cycle init was presented; m_ref the cycle of the latest REF.
   bit armed = 1'b0;
   bit m_run = 1'b0;
   int m_s = 0, m_pend = 0, m_ref = -1000000;
   int ref_cycles[$];

   task automatic model_step();
      int c, d;
      logic [3:0] e_cmd;
      logic e_rstn, e_cke, e_rdy, e_odt, e_req;
      logic [13:0] e_a;
      logic [2:0] e_ba;
      bit in_ref, done;
      c = cyc; d = c - m_s;
      e_cmd = 4'hF; e_rstn = 0; e_cke = 0; e_rdy = 0; e_odt = 0; e_a = '0; e_ba = '0;
      in_ref = 0; done = 0;
      if (m_run) begin
         e_rstn = (d > T_RST);
         e_cke  = (d >= OFF_K);
         if (d >= OFF_K) e_cmd = 4'b0111;
         if (d == OFF_M2 || d == OFF_M3 || d == OFF_M1 || d == OFF_M0) e_cmd = 4'b0000;
         if (d == OFF_Z) e_cmd = 4'b0110;
         if (d >= OFF_Z)       begin e_a = 14'h0400; e_ba = 3'd0; end
         else if (d >= OFF_M0) begin e_a = MR0; e_ba = 3'd0; end
         else if (d >= OFF_M1) begin e_a = MR1; e_ba = 3'd1; end
         else if (d >= OFF_M3) begin e_a = MR3; e_ba = 3'd3; end
         else if (d >= OFF_M2) begin e_a = MR2; e_ba = 3'd2; end
         done   = (d >= OFF_D);
         in_ref = done && (c >= m_ref) && (c < m_ref + T_RFC);
         if (done) begin
            e_rdy = !in_ref;
            e_odt = 1'b1;
            if (c == m_ref) e_cmd = 4'b0001;
         end
      end
      e_req = (m_pend != 0);
      chk("rst_n", rst_n, e_rstn);
      chk("cke", cke, e_cke);
      chk("cmd", cmd, e_cmd);
      chk("ba", ba, e_ba);
      chk("a", a, e_a);
      chk("odt", odt, e_odt);
      chk("ready", ready, e_rdy);
      chk("ref_req", ref_req, e_req);
      if (cmd === 4'b0001) ref_cycles.push_back(c);
      if (RESET) begin
         m_run = 0; m_pend = 0; m_ref = -1000000;
      end else if (!m_run) begin
         if (init) begin m_run = 1; m_s = c; end
      end else if (done && !in_ref && init) begin
         m_s = c; m_pend = 0; m_ref = -1000000;
      end
`ifdef INIT_REFRESH_EN
      else if (done) begin
         if (!in_ref && ref_ack && m_pend > 0) begin
            m_pend--;
            m_ref = c + 1;
         end
         if ((c + 1 - (m_s + OFF_D)) % T_REFI == 0) m_pend = (m_pend < 8) ? m_pend + 1 : 8;
      end
`endif
   endtask

   initial begin
      wait (armed);
      forever begin
         @(negedge clk);
         model_step();
      end
   end

   task automatic at_cycle(input int t);
      repeat (t - cyc) @(posedge clk);
      #2;
   endtask

   task automatic peek(input int t);
      repeat (t - cyc) @(posedge clk);
      #3;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready === 1'b1) break;
      end
      chk("wait_ready", ready, 1'b1);
   endtask

   task automatic ack_pulse();
      @(posedge clk); #2 ref_ack = 1'b1;
      @(posedge clk); #2 ref_ack = 1'b0;
   endtask

   task automatic start_init(output int s);
      at_cycle(cyc + 1);
      init = 1'b1;
      s = cyc;
      at_cycle(s + 1);
      init = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, s1, s2, s3, n;
      @(posedge clk); #2 armed = 1'b1;
      peek(3);
      chk("reset_rst_n", rst_n, 1'b0);
      chk("reset_cmd", cmd, 4'hF);
      chk("reset_ready", ready, 1'b0);
      at_cycle(4); RESET = 1'b0;

      // Full init with hand-derived milestones.
      start_init(s0);
      peek(s0 + 10); chk("rst_n_at10", rst_n, 1'b0);
      peek(s0 + 11); chk("rst_n_at11", rst_n, 1'b1);
      peek(s0 + 30); chk("cke_at30", cke, 1'b0);
      peek(s0 + 31); chk("cke_at31", cke, 1'b1);
      peek(s0 + 36); chk("mr2_cmd", cmd, 4'b0000); chk("mr2_ba", ba, 3'd2);
      peek(s0 + 40); chk("mr3_cmd", cmd, 4'b0000); chk("mr3_ba", ba, 3'd3);
      peek(s0 + 43); chk("pre_mr1_nop", cmd, 4'b0111);
      peek(s0 + 44); chk("mr1_cmd", cmd, 4'b0000); chk("mr1_ba", ba, 3'd1);
      chk("mr1_a", a, 14'h0044);
      peek(s0 + 45); chk("post_mr1_nop", cmd, 4'b0111); chk("mr1_a_hold", a, 14'h0044);
      peek(s0 + 48); chk("mr0_a", a, 14'h0520);
      peek(s0 + 60); chk("zq_cmd", cmd, 4'b0110); chk("zq_a", a, 14'h0400);
      peek(s0 + 89); chk("ready_at89", ready, 1'b0);
      peek(s0 + 90); chk("ready_at90", ready, 1'b1); chk("odt_at90", odt, 1'b1);

`ifndef INIT_REFRESH_EN
      ack_pulse(); ack_pulse();
      peek(cyc + 2); chk("ack_ignored_ready", ready, 1'b1);
`endif

      // Re-init from DONE.
      at_cycle(s0 + 100);
      start_init(s1);
      peek(s1 + 1); chk("reinit_ready", ready, 1'b0); chk("reinit_rst_n", rst_n, 1'b0);
      chk("reinit_cke", cke, 1'b0); chk("reinit_odt", odt, 1'b0);
      peek(s1 + 36); chk("reinit_mr2", cmd, 4'b0000);
      peek(s1 + 90); chk("reinit_ready90", ready, 1'b1);

      // Refresh accumulation then three grants.
      peek(s1 + 90 + 350);
`ifdef INIT_REFRESH_EN
      chk("pend3_req", ref_req, 1'b1);
      chk("model_pend3", m_pend, 3);
      for (int i = 0; i < 3; i++) begin
         ack_pulse();
         wait_ready();
      end
      chk("req_after3", ref_req, 1'b0);
      chk("ref_count", ref_cycles.size(), 3);
      if (ref_cycles.size() == 3) begin
         chk("ref_gap1_ok", (ref_cycles[1] - ref_cycles[0]) >= T_RFC + 1, 1'b1);
         chk("ref_gap2_ok", (ref_cycles[2] - ref_cycles[1]) >= T_RFC + 1, 1'b1);
      end
`else
      chk("no_refresh_req", ref_req, 1'b0);
`endif

      // Reset during MR3, then a clean replay.
      at_cycle(cyc + 3);
      start_init(s2);
      at_cycle(s2 + 40); RESET = 1'b1;
      peek(s2 + 40); chk("mid_mr3_cmd", cmd, 4'b0000); chk("mid_mr3_ba", ba, 3'd3);
      at_cycle(s2 + 41); RESET = 1'b0;
      peek(s2 + 41); chk("mid_rst_rst_n", rst_n, 1'b0); chk("mid_rst_cmd", cmd, 4'hF);
      chk("mid_rst_a", a, 14'h0000); chk("mid_rst_cke", cke, 1'b0);
      start_init(s3);
      peek(s3 + 36); chk("replay_mr2", cmd, 4'b0000);
      peek(s3 + 60); chk("replay_zq", cmd, 4'b0110);
      peek(s3 + 90); chk("replay_ready", ready, 1'b1);

      // Long wait without grants: pending saturates.
      peek(s3 + 90 + 1000);
`ifdef INIT_REFRESH_EN
      chk("sat_req", ref_req, 1'b1);
      chk("model_pend_sat", m_pend, 8);
      n = 0;
      while (ref_req === 1'b1 && n < 20) begin
         ack_pulse();
         wait_ready();
         n++;
      end
      chk("sat_drained", ref_req, 1'b0);
`else
      chk("sat_off_req", ref_req, 1'b0);
      chk("no_ref_cmds", ref_cycles.size(), 0);
`endif

      at_cycle(cyc + 5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
